// File: rtl/iir_biquad_cascade.sv
// Cascade of SECTIONS direct-form-II biquads sharing one multiply-accumulate
// datapath. Five MAC steps per section; samples move through valid/ready.
module iir_biquad_cascade #(
  parameter int WIDTH    = 31,
  parameter int FRAC     = 16,
  parameter int SECTIONS = 2
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [WIDTH:0]                                    x,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [WIDTH:0]                                    y,
  input  logic                                              coef_we,
  input  logic [((SECTIONS > 1) ? $clog2(SECTIONS) : 1)-1:0] coef_sec,
  input  logic [2:0]                                        coef_idx,
  input  logic [WIDTH:0]                                    coef_data,
  input  logic                                              clear_state,
  output logic                                              busy
);

  localparam int W  = WIDTH + 1;
  localparam int AW = W + 4;
  localparam int SW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

  localparam logic signed [AW-1:0] ACC_MAX  = {{(AW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN  = {{(AW-WIDTH){1'b1}}, {WIDTH{1'b0}}};
  localparam logic signed [WIDTH:0] ONE     = {{(W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [SW-1:0]         SEC_LAST = SW'(SECTIONS - 1);
  localparam logic [2:0]            STEP_LAST = 3'd4;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           sec_q, sec_d;
  logic [2:0]              step_q, step_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [WIDTH:0]   u_q, u_d;
  logic signed [WIDTH:0]   w_q, w_d;
  logic [WIDTH:0]          y_q, y_d;
  logic signed [WIDTH:0]   coef_q [SECTIONS][5];
  logic signed [WIDTH:0]   coef_d [SECTIONS][5];
  logic signed [WIDTH:0]   w1_q [SECTIONS];
  logic signed [WIDTH:0]   w1_d [SECTIONS];
  logic signed [WIDTH:0]   w2_q [SECTIONS];
  logic signed [WIDTH:0]   w2_d [SECTIONS];

  logic signed [WIDTH:0]   mul_a, mul_b;
  logic signed [2*W-1:0]   prod;
  logic signed [AW-1:0]    term;
  logic signed [AW-1:0]    acc_n;

  function automatic logic signed [WIDTH:0] sat(input logic signed [AW-1:0] a);
    if (a > ACC_MAX)      return ACC_MAX[WIDTH:0];
    else if (a < ACC_MIN) return ACC_MIN[WIDTH:0];
    else                  return a[WIDTH:0];
  endfunction

  // State and datapath registers; reset restores pass-through coefficients
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sec_q   <= '0;
      step_q  <= '0;
      acc_q   <= '0;
      u_q     <= '0;
      w_q     <= '0;
      y_q     <= '0;
      for (int unsigned s = 0; s < SECTIONS; s++) begin
        w1_q[s]      <= '0;
        w2_q[s]      <= '0;
        coef_q[s][0] <= ONE;
        coef_q[s][1] <= '0;
        coef_q[s][2] <= '0;
        coef_q[s][3] <= '0;
        coef_q[s][4] <= '0;
      end
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      u_q     <= u_d;
      w_q     <= w_d;
      y_q     <= y_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      coef_q  <= coef_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = MAC;
      MAC:  if (step_q == STEP_LAST && sec_q == SEC_LAST) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    y         = y_q;
  end

  // Shared multiplier operand select: coefficient x delay/intermediate word
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (step_q)
      3'd0: begin mul_a = coef_q[sec_q][3]; mul_b = w1_q[sec_q]; end
      3'd1: begin mul_a = coef_q[sec_q][4]; mul_b = w2_q[sec_q]; end
      3'd2: begin mul_a = coef_q[sec_q][0]; mul_b = w_q;         end
      3'd3: begin mul_a = coef_q[sec_q][1]; mul_b = w1_q[sec_q]; end
      3'd4: begin mul_a = coef_q[sec_q][2]; mul_b = w2_q[sec_q]; end
      default: ;
    endcase
    prod = mul_a * mul_b;
    term = AW'(prod >>> FRAC);
  end

  // Datapath update: coefficient writes/clears in IDLE (write and clear land
  // before the accepted sample is processed), MAC sequencing otherwise
  always_comb begin
    sec_d  = sec_q;
    step_d = step_q;
    acc_d  = acc_q;
    u_d    = u_q;
    w_d    = w_q;
    y_d    = y_q;
    w1_d   = w1_q;
    w2_d   = w2_q;
    coef_d = coef_q;
    acc_n  = '0;
    case (state_q)
      IDLE: begin
        if (coef_we && int'(coef_sec) < SECTIONS && coef_idx < 3'd5)
          coef_d[coef_sec][coef_idx] = coef_data;
        if (clear_state) begin
          for (int unsigned s = 0; s < SECTIONS; s++) begin
            w1_d[s] = '0;
            w2_d[s] = '0;
          end
        end
        if (in_valid) begin
          u_d    = x;
          sec_d  = '0;
          step_d = '0;
        end
      end
      MAC: begin
        case (step_q)
          3'd0: begin
            acc_d  = AW'(u_q) - term;
            step_d = 3'd1;
          end
          3'd1: begin
            acc_n  = acc_q - term;
            acc_d  = acc_n;
            w_d    = sat(acc_n);
            step_d = 3'd2;
          end
          3'd2: begin
            acc_d  = term;
            step_d = 3'd3;
          end
          3'd3: begin
            acc_d  = acc_q + term;
            step_d = 3'd4;
          end
          default: begin
            acc_n         = acc_q + term;
            acc_d         = acc_n;
            u_d           = sat(acc_n);
            w2_d[sec_q]   = w1_q[sec_q];
            w1_d[sec_q]   = w_q;
            step_d        = '0;
            if (sec_q == SEC_LAST) y_d = sat(acc_n);
            else                   sec_d = sec_q + SW'(1);
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Testbench for iir_biquad_cascade: vector table plus hand-written sequences
// for latency, output backpressure and mid-computation reset.
module tb_iir_biquad_cascade;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        coef_we;
  logic [0:0]  coef_sec;
  logic [2:0]  coef_idx;
  logic [31:0] coef_data;
  logic        clear_state;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          rst_first;
    bit          clr;
    bit          cwe;
    bit [0:0]    csec;
    bit [2:0]    cidx;
    logic [31:0] cval;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[21];

  iir_biquad_cascade #(.WIDTH(31), .FRAC(16), .SECTIONS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .coef_we(coef_we), .coef_sec(coef_sec), .coef_idx(coef_idx),
    .coef_data(coef_data), .clear_state(clear_state), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit c, bit we, bit [0:0] s, bit [2:0] i,
                              logic [31:0] v, logic [31:0] xi, logic [31:0] yo);
    vec_t t;
    t.rst_first = r; t.clr = c; t.cwe = we; t.csec = s; t.cidx = i;
    t.cval = v; t.x = xi; t.y = yo;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare every accepted output against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra got %h want none", y);
      end else begin
        check("sb_y", y, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy want idle");
    end
  endtask

  task automatic do_reset();
    wait_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input vec_t v);
    wait_idle();
    in_valid    = 1'b1;
    x           = v.x;
    coef_we     = v.cwe;
    coef_sec    = v.csec;
    coef_idx    = v.cidx;
    coef_data   = v.cval;
    clear_state = v.clr;
    exp_q.push_back(v.y);
    tick();
    in_valid    = 1'b0;
    coef_we     = 1'b0;
    clear_state = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_sec = '0; coef_idx = '0; coef_data = '0; clear_state = 1'b0;

    //            rst clr we sec idx coef          x             y
    vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,         32'h00030000, 32'h00030000);
    vecs[1]  = mk(1, 0, 1, 0, 3, 32'hFFFF8000,  32'h00010000, 32'h00010000);
    vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00008000);
    vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00004000);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00002000);
    vecs[5]  = mk(0, 1, 0, 0, 0, 32'h0,         32'h00000000, 32'h00000000);
    vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h00010000, 32'h00010000);
    vecs[7]  = mk(1, 0, 1, 0, 0, 32'h00040000,  32'h40000000, 32'h7FFFFFFF);
    vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,         32'hC0000000, 32'h80000000);
    vecs[9]  = mk(1, 0, 1, 0, 0, 32'h00008000,  32'hFFFFFFFF, 32'hFFFFFFFF);
    vecs[10] = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000001, 32'h00000000);
    vecs[11] = mk(1, 0, 1, 0, 1, 32'h00008000,  32'h00010000, 32'h00010000);
    vecs[12] = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00008000);
    vecs[13] = mk(1, 0, 1, 0, 4, 32'hFFFF0000,  32'h00010000, 32'h00010000);
    vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00000000);
    vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00010000);
    vecs[16] = mk(1, 0, 1, 0, 5, 32'h00040000,  32'h00010000, 32'h00010000);
    vecs[17] = mk(1, 0, 1, 0, 2, 32'hFFFF0000,  32'h00030000, 32'h00030000);
    vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'h00000000);
    vecs[19] = mk(0, 0, 0, 0, 0, 32'h0,         32'h00000000, 32'hFFFD0000);
    vecs[20] = mk(1, 0, 1, 1, 0, 32'h00020000,  32'h00010000, 32'h00020000);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_y", y, 32'h0);

    // Pass-through latency: out_valid exactly 11 cycles after accept, one cycle wide
    in_valid = 1'b1;
    x = 32'h00030000;
    exp_q.push_back(32'h00030000);
    tick();
    in_valid = 1'b0;
    n = 1;
    check("mac_busy", busy, 1);
    check("mac_in_ready", in_ready, 0);
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, 11);
    tick();
    check("ov_one_cycle", out_valid, 0);
    check("in_ready_after", in_ready, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      send(vecs[i]);
    end

    // Backpressure in OUT: y held, nothing accepted, coefficient write ignored
    do_reset();
    out_ready = 1'b0;
    send(mk(0, 0, 0, 0, 0, 32'h0, 32'h00010000, 32'h00010000));
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("hold_reached", out_valid, 1);
    in_valid = 1'b1; x = 32'h00050000;
    coef_we = 1'b1; coef_sec = 1'b0; coef_idx = 3'd0; coef_data = 32'h00020000;
    for (int i = 0; i < 5; i++) begin
      check("hold_y", y, 32'h00010000);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      tick();
    end
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    tick();
    send(mk(0, 0, 0, 0, 0, 32'h0, 32'h00010000, 32'h00010000));

    // Reset at MAC step2 of section 1 discards the sample and the written coefficients
    do_reset();
    coef_we = 1'b1; coef_sec = 1'b0; coef_idx = 3'd0; coef_data = 32'h00020000;
    tick();
    coef_sec = 1'b1; coef_data = 32'h00030000;
    tick();
    coef_we = 1'b0;
    in_valid = 1'b1; x = 32'h00010000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_valid = 1'b0;
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_y", y, 32'h0);
    send(mk(0, 0, 0, 0, 0, 32'h0, 32'h00020000, 32'h00020000));

    wait_idle();
    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iir_biquad_cascade.md
Name: iir_biquad_cascade

Overview:
- Parametrised successor to the first-order IIR stage: a cascade of SECTIONS second-order (biquad) direct-form-II sections, all computed on one time-multiplexed multiply-accumulate datapath.
- Samples enter and leave through valid/ready handshakes.
- Coefficients are runtime-writable per section.
- Delay-line state is held in registers and can be cleared on demand.

Parameters:
- WIDTH, 31: MSB index. Data, coefficient and state words are WIDTH+1 bits, two's complement.
- FRAC, 16: fractional bits of every word (Q(WIDTH+1-FRAC).FRAC).
- SECTIONS, 2: number of cascaded biquads, 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample x is valid.
- in_ready  out  1  block can accept a sample.
- x  in  WIDTH+1  input sample.
- out_valid  out  1  y is valid.
- out_ready  in  1  consumer accepts y.
- y  out  WIDTH+1  output sample.
- coef_we  in  1  coefficient write strobe.
- coef_sec  in  max(1,$clog2(SECTIONS))  target section.
- coef_idx  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 are ignored.
- coef_data  in  WIDTH+1  coefficient value.
- clear_state  in  1  zero all delay lines.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Section equations, for section input u:
  - w = sat(u − a1·w1 − a2·w2)
  - v = sat(b0·w + b1·w1 + b2·w2)
  - then w2 ← w1, w1 ← w
  - v of section s is u of section s+1. u of section 0 is x; v of the last section is y.
- Product rule: full 2(WIDTH+1)-bit signed product, arithmetic shift right by FRAC (floor, no rounding).
- Accumulator: WIDTH+1+4 bits (4 guard bits).
- sat(): clamp the accumulator to [−2^WIDTH, 2^WIDTH−1].
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - When in_valid=1: latch x, set section=0 and step=0, go to MAC.
- MAC: 5 steps per section, one per cycle.
  - step0: acc = u − a1·w1.
  - step1: acc −= a2·w2; latch w = sat(acc).
  - step2: acc = b0·w.
  - step3: acc += b1·w1.
  - step4: acc += b2·w2; v = sat(acc); shift this section's delay line.
  - After step4: if section<SECTIONS−1, go to section+1 with step=0; else register y and go to OUT.
- OUT:
  - out_valid=1; y is stable until out_ready=1.
  - On out_ready=1: return to IDLE; out_valid falls on the next cycle.
- Latency: accept cycle to out_valid is 5·SECTIONS+1 cycles (11 at default). Throughput is one sample per 5·SECTIONS+2 cycles.
- in_ready=0 in MAC and OUT. No input is accepted while busy.
- Coefficient writes:
  - Take effect only in IDLE; coef_we in MAC or OUT is ignored.
  - Writes to coef_sec ≥ SECTIONS or coef_idx ≥ 5 are ignored.
  - coef_we and in_valid in the same IDLE cycle: the write lands first, and the sample uses the new value.
- clear_state:
  - Honoured only in IDLE; zeroes all w1/w2.
  - clear_state together with in_valid: clear first, then process the sample from zero state.
- Reset (any state, including mid-MAC or OUT):
  - state=IDLE, in_ready=1, out_valid=0, y=0, busy=0.
  - All w1/w2=0, accumulator=0.
  - Every section's coefficients: b0=1<<FRAC (1.0), b1=b2=a1=a2=0, so the block passes x through unchanged.
  - Any in-flight sample is discarded.

Test Plan:
1. Reset, then x=0x00030000 with out_ready=1 → y=0x00030000 exactly 11 cycles after accept, out_valid for one cycle, then in_ready=1.
2. Section0 a1=0xFFFF8000 (−0.5); inputs x=0x00010000, 0, 0 → y=0x00010000, 0x00008000, 0x00004000.
3. Section0 b0=0x00040000 (4.0); x=0x40000000 → y=0x7FFFFFFF; x=0xC0000000 → y=0x80000000.
4. Hold out_ready=0 for 5 cycles in OUT while in_valid=1 and coef_we=1 → y stable, in_ready=0, no sample accepted, coefficient unchanged.
5. Assert rst at MAC step2 of section1 → next cycle out_valid=0, in_ready=1. A following x=0x00020000 passes through as 0x00020000 even though coefficients were written before the reset.
6. After scenario 2 leaves nonzero state, pulse clear_state in IDLE, then x=0 → y=0 (without the clear, y=0x00002000).
